// File: rtl/bp_be_pkg.sv
// Shared types for the backend stride prefetch scheduler.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_issue = 2'd1,
    e_drain = 2'd2
  } bp_be_pf_state_e;

endpackage

// File: rtl/bsg_counter_up_down.sv
// Single-step up/down counter with synchronous clear; up and down together hold.
module bsg_counter_up_down #(
  parameter int unsigned width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (up_i && !down_i) begin
      count_o <= count_o + width_p'(1);
    end else if (down_i && !up_i) begin
      count_o <= count_o - width_p'(1);
    end
  end

endmodule

// File: rtl/bp_be_stride_prefetch_sched.sv
// Issues stride prefetches for a loop descriptor, throttled by demand commits
// (prefetch distance) and by unacknowledged requests (credits).
module bp_be_stride_prefetch_sched
  import bp_be_pkg::*;
#(
  parameter int unsigned vaddr_width_p  = 39,
  parameter int unsigned output_range_p = 8,
  parameter int unsigned stride_width_p = 8,
  parameter int unsigned pf_distance_p  = 4,
  parameter int unsigned credits_p      = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      loop_v_i,
  output logic                      loop_yumi_o,
  input  logic [output_range_p-1:0] loop_iter_i,
  input  logic [vaddr_width_p-1:0]  loop_pc_i,
  input  logic [vaddr_width_p-1:0]  loop_addr_i,
  input  logic [stride_width_p-1:0] loop_stride_i,
  input  logic                      commit_v_i,
  input  logic [vaddr_width_p-1:0]  commit_pc_i,
  input  logic                      flush_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_and_i,
  input  logic                      pf_ack_i,
  output logic                      busy_o
);

  localparam int unsigned ahead_width_lp  = $clog2(pf_distance_p + 1);
  localparam int unsigned credit_width_lp = $clog2(credits_p + 1);

  bp_be_pf_state_e state_r, state_n;

  logic [vaddr_width_p-1:0]   pc_r, addr_r, stride_r, stride_ext;
  logic [output_range_p-1:0]  remain_r;
  logic [ahead_width_lp-1:0]  ahead_r;
  logic [credit_width_lp-1:0] outstanding_r, outstanding_after;
  logic                       accept, issue, commit_hit, ack_hit;

  assign stride_ext        = vaddr_width_p'($signed(loop_stride_i));
  assign accept            = loop_yumi_o;
  assign issue             = pf_v_o & pf_ready_and_i;
  assign commit_hit        = commit_v_i && (state_r != e_idle) && (commit_pc_i == pc_r) && (ahead_r != '0);
  assign ack_hit           = pf_ack_i && (outstanding_r != '0);
  assign outstanding_after = outstanding_r - credit_width_lp'(ack_hit);

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:  if (loop_v_i && (loop_iter_i != '0)) state_n = e_issue;
      e_issue: begin
        if (flush_i)
          state_n = (outstanding_after == '0) ? e_idle : e_drain;
        else if (issue && (remain_r == output_range_p'(1)))
          state_n = e_drain;
      end
      e_drain: if (outstanding_after == '0) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  // Outputs; the request stays stable because its enables only relax until handshake
  always_comb begin
    loop_yumi_o = 1'b0;
    pf_v_o      = 1'b0;
    pf_addr_o   = addr_r;
    busy_o      = (state_r != e_idle);
    case (state_r)
      e_idle:  loop_yumi_o = loop_v_i & reset_n_i;
      e_issue: pf_v_o = (remain_r != '0)
                     && (ahead_r < ahead_width_lp'(pf_distance_p))
                     && (outstanding_r < credit_width_lp'(credits_p))
                     && !flush_i;
      default: ;
    endcase
  end

  // Stream datapath; address arithmetic wraps modulo 2^vaddr_width_p
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_r     <= '0;
      addr_r   <= '0;
      stride_r <= '0;
      remain_r <= '0;
    end else if (accept) begin
      pc_r     <= loop_pc_i;
      addr_r   <= loop_addr_i + stride_ext;
      stride_r <= stride_ext;
      remain_r <= loop_iter_i;
    end else if ((state_r == e_issue) && flush_i) begin
      remain_r <= '0;
    end else if (issue) begin
      addr_r   <= addr_r + stride_r;
      remain_r <= remain_r - output_range_p'(1);
    end
  end

  bsg_counter_up_down #(.width_p(ahead_width_lp)) ahead_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (accept),
    .up_i      (issue),
    .down_i    (commit_hit),
    .count_o   (ahead_r)
  );

  bsg_counter_up_down #(.width_p(credit_width_lp)) outstanding_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (1'b0),
    .up_i      (issue),
    .down_i    (ack_hit),
    .count_o   (outstanding_r)
  );

endmodule

// File: tb/tb_bp_be_stride_prefetch_sched.sv
// Bench for the stride prefetch scheduler: directed scenarios plus random traffic
// checked every cycle against a stream-level reference model.
module tb_bp_be_stride_prefetch_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        loop_v, loop_yumi;
  logic [7:0]  loop_iter;
  logic [38:0] loop_pc, loop_addr;
  logic [7:0]  loop_stride;
  logic        commit_v;
  logic [38:0] commit_pc;
  logic        flush;
  logic        pf_v;
  logic [38:0] pf_addr;
  logic        pf_ready, pf_ack, busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: stream = base + k*stride for k = 1..iter
  bit          m_busy;
  longint      m_base, m_stride;
  logic [38:0] m_pc;
  int          m_k, m_iter, m_ahead, m_out;

  logic        obs_v, obs_yumi;
  logic [38:0] obs_addr;

  always #5 clk = ~clk;

  bp_be_stride_prefetch_sched dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .loop_v_i       (loop_v),
    .loop_yumi_o    (loop_yumi),
    .loop_iter_i    (loop_iter),
    .loop_pc_i      (loop_pc),
    .loop_addr_i    (loop_addr),
    .loop_stride_i  (loop_stride),
    .commit_v_i     (commit_v),
    .commit_pc_i    (commit_pc),
    .flush_i        (flush),
    .pf_v_o         (pf_v),
    .pf_addr_o      (pf_addr),
    .pf_ready_and_i (pf_ready),
    .pf_ack_i       (pf_ack),
    .busy_o         (busy)
  );

  task automatic model_reset();
    m_busy = 0; m_base = 0; m_stride = 0; m_pc = '0;
    m_k = 0; m_iter = 0; m_ahead = 0; m_out = 0;
  endtask

  // One clock: compare at negedge, advance model, return just after posedge
  task automatic cycle(input string tag);
    logic ev, ey;
    logic [38:0] ea;
    bit issue, commit_hit, ack_hit, drain_ph, flush_iss, accept;
    @(negedge clk);
    ev = m_busy && (m_k < m_iter) && (m_ahead < 4) && (m_out < 2) && !flush;
    ea = 39'(m_base + (longint'(m_k) + 1) * m_stride);
    ey = !m_busy && loop_v;
    obs_v = pf_v; obs_addr = pf_addr; obs_yumi = loop_yumi;
    n_cmp++;
    if (pf_v !== ev) begin n_fail++; $display("FAIL %s pf_v got %0b exp %0b t=%0t", tag, pf_v, ev, $time); end
    n_cmp++;
    if (loop_yumi !== ey) begin n_fail++; $display("FAIL %s yumi got %0b exp %0b t=%0t", tag, loop_yumi, ey, $time); end
    n_cmp++;
    if (busy !== m_busy) begin n_fail++; $display("FAIL %s busy got %0b exp %0b t=%0t", tag, busy, m_busy, $time); end
    if (ev) begin
      n_cmp++;
      if (pf_addr !== ea) begin n_fail++; $display("FAIL %s pf_addr got %h exp %h t=%0t", tag, pf_addr, ea, $time); end
    end
    issue      = ev && pf_ready;
    accept     = ey;
    commit_hit = m_busy && commit_v && (commit_pc == m_pc) && (m_ahead > 0);
    ack_hit    = pf_ack && (m_out > 0);
    drain_ph   = m_busy && (m_k >= m_iter);
    flush_iss  = m_busy && flush && (m_k < m_iter);
    m_ahead += int'(issue) - int'(commit_hit);
    m_out   += int'(issue) - int'(ack_hit);
    if (issue) m_k++;
    if (flush_iss) m_iter = m_k;
    if ((drain_ph || flush_iss) && m_out == 0) m_busy = 0;
    if (accept) begin
      m_base = longint'(loop_addr); m_stride = longint'($signed(loop_stride));
      m_pc = loop_pc; m_iter = int'(loop_iter); m_k = 0; m_ahead = 0;
      m_busy = (loop_iter != 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_desc(input int iter, input logic [38:0] addr, input logic [7:0] stride,
                           input logic [38:0] pc);
    loop_v = 1; loop_iter = 8'(iter); loop_addr = addr; loop_stride = stride; loop_pc = pc;
    cycle("accept");
    loop_v = 0;
  endtask

  task automatic settle();
    for (int c = 0; c < 40 && busy; c++) begin
      pf_ack = 1; flush = 1; cycle("settle");
    end
    pf_ack = 0; flush = 0;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL settle busy got %0b exp 0", busy); end
  endtask

  task automatic test_reset();
    reset_n = 0; loop_v = 1; loop_iter = 8'd3; loop_addr = 39'h123; loop_stride = 8'd4;
    loop_pc = 39'h40; commit_v = 0; commit_pc = '0; flush = 0; pf_ready = 1; pf_ack = 1;
    #2;
    n_cmp++; if (loop_yumi !== 1'b0) begin n_fail++; $display("FAIL reset yumi got %0b exp 0", loop_yumi); end
    n_cmp++; if (pf_v !== 1'b0) begin n_fail++; $display("FAIL reset pf_v got %0b exp 0", pf_v); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %0b exp 0", busy); end
    n_cmp++; if (pf_addr !== '0) begin n_fail++; $display("FAIL reset pf_addr got %h exp 0", pf_addr); end
    loop_v = 0; pf_ack = 0; pf_ready = 0;
    @(posedge clk); #1;
    reset_n = 1; model_reset();
  endtask

  task automatic test_basic();
    logic [38:0] got [3];
    logic [38:0] expv [3];
    int n = 0;
    expv[0] = 39'h1008; expv[1] = 39'h1010; expv[2] = 39'h1018;
    send_desc(3, 39'h1000, 8'd8, 39'h100);
    pf_ready = 1; pf_ack = 0;
    for (int c = 0; c < 30 && (n < 3 || busy); c++) begin
      cycle("basic");
      if (obs_v && pf_ready) begin
        if (n < 3) got[n] = obs_addr;
        n++;
      end
      pf_ack = obs_v && pf_ready;
    end
    pf_ack = 0;
    n_cmp++; if (n != 3) begin n_fail++; $display("FAIL basic issues got %0d exp 3", n); end
    for (int i = 0; i < 3 && i < n; i++) begin
      n_cmp++;
      if (got[i] !== expv[i]) begin n_fail++; $display("FAIL basic addr%0d got %h exp %h", i, got[i], expv[i]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic busy_end got %0b exp 0", busy); end
  endtask

  task automatic test_neg_stride();
    logic [38:0] got [2];
    int n = 0;
    send_desc(2, 39'h2000, 8'hF0, 39'h200);
    pf_ready = 1; pf_ack = 1;
    for (int c = 0; c < 20 && (n < 2 || busy); c++) begin
      cycle("neg");
      if (obs_v) begin
        if (n < 2) got[n] = obs_addr;
        n++;
      end
    end
    pf_ack = 0;
    n_cmp++; if (n != 2) begin n_fail++; $display("FAIL neg issues got %0d exp 2", n); end
    n_cmp++; if (got[0] !== 39'h1FF0) begin n_fail++; $display("FAIL neg addr0 got %h exp 1ff0", got[0]); end
    n_cmp++; if (got[1] !== 39'h1FE0) begin n_fail++; $display("FAIL neg addr1 got %h exp 1fe0", got[1]); end
  endtask

  task automatic count_issues(input string tag, input int cycles, input int expn);
    int n = 0;
    for (int c = 0; c < cycles; c++) begin
      cycle(tag);
      commit_v = 0;
      if (obs_v && pf_ready) n++;
    end
    n_cmp++;
    if (n != expn) begin n_fail++; $display("FAIL %s issues got %0d exp %0d", tag, n, expn); end
  endtask

  task automatic test_distance();
    logic [38:0] p = 39'h3A0;
    send_desc(10, 39'h8000, 8'd64, p);
    pf_ready = 1; pf_ack = 1;
    count_issues("dist_fill", 10, 4);
    n_cmp++; if (obs_v !== 1'b0) begin n_fail++; $display("FAIL dist_stall pf_v got %0b exp 0", obs_v); end
    commit_v = 1; commit_pc = p;
    count_issues("dist_hit", 6, 1);
    commit_v = 1; commit_pc = p ^ 39'h4;
    count_issues("dist_miss", 6, 0);
    settle();
  endtask

  task automatic test_stall();
    send_desc(2, 39'h3000, 8'd4, 39'h300);
    pf_ready = 0; pf_ack = 0;
    for (int c = 0; c < 5; c++) begin
      cycle("stall");
      n_cmp++;
      if (obs_v !== 1'b1 || obs_addr !== 39'h3004) begin
        n_fail++; $display("FAIL stall hold got v=%0b addr=%h exp v=1 addr=3004", obs_v, obs_addr);
      end
    end
    flush = 1; pf_ready = 1;
    cycle("stall_flush");
    flush = 0;
    n_cmp++; if (obs_v !== 1'b0) begin n_fail++; $display("FAIL stall_flush pf_v got %0b exp 0", obs_v); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_flush busy got %0b exp 0", busy); end
  endtask

  task automatic test_flush();
    send_desc(8, 39'h4000, 8'd16, 39'h400);
    pf_ready = 1; pf_ack = 0;
    count_issues("flush_fill", 3, 2);
    flush = 1;
    cycle("flush");
    flush = 0;
    n_cmp++; if (obs_v !== 1'b0) begin n_fail++; $display("FAIL flush pf_v got %0b exp 0", obs_v); end
    for (int c = 0; c < 3; c++) begin
      cycle("flush_wait");
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_wait busy got %0b exp 1", busy); end
    end
    pf_ack = 1;
    cycle("flush_ack1");
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_ack1 busy got %0b exp 1", busy); end
    cycle("flush_ack2");
    pf_ack = 0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_ack2 busy got %0b exp 0", busy); end
    send_desc(1, 39'h5000, 8'd8, 39'h500);
    n_cmp++; if (obs_yumi !== 1'b1) begin n_fail++; $display("FAIL flush_new yumi got %0b exp 1", obs_yumi); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_new busy got %0b exp 1", busy); end
    settle();
  endtask

  task automatic test_reset_mid();
    send_desc(5, 39'h6000, 8'd8, 39'h600);
    pf_ready = 0;
    cycle("mid");
    #2; reset_n = 0; #1;
    n_cmp++; if (pf_v !== 1'b0) begin n_fail++; $display("FAIL mid_reset pf_v got %0b exp 0", pf_v); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset busy got %0b exp 0", busy); end
    n_cmp++; if (pf_addr !== '0) begin n_fail++; $display("FAIL mid_reset pf_addr got %h exp 0", pf_addr); end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1;
    pf_ack = 1;
    cycle("mid_ack");
    cycle("mid_ack");
    pf_ack = 0;
    send_desc(2, 39'h7000, 8'd8, 39'h700);
    pf_ready = 1; pf_ack = 1;
    count_issues("mid_after", 4, 2);
    settle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      loop_v    = ($urandom_range(0, 9) < 3);
      loop_iter = 8'($urandom_range(0, 12));
      loop_addr = ($urandom_range(0, 3) == 0) ? 39'h7F_FFFF_FFC0 + 39'($urandom_range(0, 63))
                                              : 39'({$urandom(), $urandom()});
      loop_stride = 8'($urandom());
      loop_pc   = 39'($urandom_range(0, 3)) << 2;
      commit_v  = ($urandom_range(0, 9) < 4);
      commit_pc = ($urandom_range(0, 2) != 0) ? m_pc : 39'($urandom_range(0, 3)) << 2;
      flush     = ($urandom_range(0, 39) == 0);
      pf_ready  = ($urandom_range(0, 9) < 7);
      pf_ack    = ($urandom_range(0, 1) == 1);
      cycle("rand");
    end
    loop_v = 0; commit_v = 0; flush = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_neg_stride();
    test_distance();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
